inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction fetch sequencer that sits between the PC/branch logic and the word-addressed, combinational-read instruction memory. It drives the memory word address and realigns the returned 32-bit words into RV32IC instructions of 16 or 32 bits, including 32-bit instructions that straddle a word boundary. Each instruction is presented to decode through a registered valid/ready slot, and a redirect port flushes and restarts fetch at any halfword-aligned target.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width (64 words).
- `RESET_PC`, default 0: byte address fetched after reset; bit 0 is ignored.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_en` in 1: when 0, no new instruction is loaded into the output slot; state is held.
- `redirect_valid` in 1: flush and restart at `redirect_pc`.
- `redirect_pc` in ADDR_W+2: byte target; bit 0 is ignored.
- `mem_addr` out ADDR_W: word address to the instruction memory; driven only from a register.
- `mem_data` in 32: word read combinationally at `mem_addr`.
- `inst_valid` out 1: output slot holds an instruction.
- `inst_ready` in 1: decode accepts the slot this cycle.
- `inst_data` out 32: instruction; compressed instructions are zero-extended to `{16'h0, hw}`.
- `inst_pc` out ADDR_W+2: byte address of `inst_data`.
- `inst_is_c` out 1: instruction is 16-bit.

## Operation
- Registers:
  - `pc`: byte address of the next instruction.
  - `wptr`: next word to read; drives `mem_addr`.
  - `hold[15:0]`: buffered upper halfword.
  - `state`.
  - The output slot.
- An instruction is compressed when its low halfword has `[1:0] != 2'b11`.
- The slot loads only when `fetch_en=1` and (`!inst_valid` or `inst_ready`). Call this "advance."
- State ALIGN (next instruction at `mem_data[15:0]`):
  - If compressed: emit `mem_data[15:0]`; `hold<=mem_data[31:16]`; `wptr+1`; `pc+2`; go to HALF.
  - Else: emit `mem_data`; `wptr+1`; `pc+4`; stay in ALIGN.
- State HALF (next instruction starts in `hold`):
  - If `hold` is compressed: emit `hold`; `pc+2`; go to ALIGN. No memory word is consumed and `wptr` is unchanged.
  - Else: emit `{mem_data[15:0], hold}`; `hold<=mem_data[31:16]`; `wptr+1`; `pc+4`; stay in HALF.
- State UNALIGNED (target at the upper half of word `wptr`):
  - `hold<=mem_data[31:16]`; `wptr+1`; go to HALF.
  - Nothing is emitted (one bubble). This step does not require advance, only `fetch_en`.
- Redirect:
  - Highest priority over all other actions.
  - `pc<=redirect_pc & ~1`; `wptr<=redirect_pc[ADDR_W+1:2]`.
  - Next state is ALIGN if `redirect_pc[1]=0`, otherwise UNALIGNED.
  - `inst_valid<=0` and `hold` is discarded.
  - If `inst_ready` is high in the same cycle, the handshake still counts as accepted, but no new instruction loads.
- Arithmetic: `pc` wraps modulo 2^(ADDR_W+2) and `wptr` wraps modulo 2^ADDR_W. Fetch continues from word 0 after the last word.
- Reset values:
  - `pc=RESET_PC & ~1`; `wptr=RESET_PC[ADDR_W+1:2]`.
  - `state` is ALIGN or UNALIGNED according to `RESET_PC[1]`.
  - `hold=0`; `inst_valid=0`; `inst_data=0`; `inst_pc=0`; `inst_is_c=0`.
  - `mem_addr` equals the reset `wptr`.
  - A `rst` asserted mid-stream overrides redirect and everything else.

## Timing
- `mem_addr` comes from a register; `mem_data` is used in the same cycle.
- Latency: an instruction whose bytes are present in `mem_data`/`hold` during cycle N is in the slot (`inst_valid=1`) in cycle N+1.
- Throughput is one instruction per cycle while decode is ready, including the straddle case.
- First instruction after reset or redirect:
  - `inst_valid=1` two cycles later for an aligned target.
  - Three cycles later for a target with `pc[1]=1`.
- While `inst_valid && !inst_ready`, the slot contents stay stable and `pc`, `wptr`, `hold`, and `state` are frozen.

## Structure
- A shared package holds the `fetch_state_t` encoding (ALIGN=2'd0, HALF=2'd1, UNALIGNED=2'd2) and the constant `OPC_32BIT = 2'b11`.
- One combinational sub-module, `fetch_align`. Inputs: `state`, `hold`, `mem_data`. Outputs:
  - candidate instruction;
  - `is_c`;
  - `consume_word`;
  - `pc_inc` (2 or 4);
  - `next_state`;
  - `emit`.
- The top level holds the registers, the handshake, and redirect priority.

## Test plan
- Reset with `RESET_PC=0`, word0=`32'h01400513`, `inst_ready=1` → cycle 2 shows `inst_valid=1`, `inst_data=32'h01400513`, `inst_pc=0`, `inst_is_c=0`, and `mem_addr=1`.
- word0=`32'h45854505` → `32'h00004505` at pc 0 (`is_c=1`), then `32'h00004585` at pc 2 on the next cycle, with `mem_addr` incrementing only once.
- Straddle: word0=`32'h05134505`, word1=`32'hXXXX0140` → `32'h00004505` at pc 0, then `32'h01400513` at pc 2 with `is_c=0`.
- Hold `inst_ready=0` for 3 cycles with `inst_valid=1` → `inst_data`, `inst_pc`, and `mem_addr` are unchanged. Releasing ready gives the next instruction one cycle later.
- Redirect to `8'h0E` (pc[1]=1) with word3=`32'h4505XXXX` → `inst_valid` drops the next cycle, one bubble follows, then `32'h00004505` appears at pc `8'h0E`. A redirect asserted together with `inst_ready` drops the slot.
- Fetch sequentially through word 63 → `mem_addr` wraps to 0 and `inst_pc` wraps to 0. `rst` asserted mid-straddle → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t : realignment state (ALIGN / HALF / UNALIGNED)
//   OPC_32BIT     : low two bits that mark a 32-bit (non-compressed) instruction
//   is_compressed : true when a halfword starts a 16-bit instruction
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ALIGN     = 2'd0,  // next instruction starts at mem_data[15:0]
        HALF      = 2'd1,  // next instruction starts in the hold register
        UNALIGNED = 2'd2   // target is the upper half of word wptr; prime hold first
    } fetch_state_t;

    localparam logic [1:0] OPC_32BIT = 2'b11;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != OPC_32BIT;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fetch_align.sv
// Combinational realignment step. From the current state, the buffered upper
// halfword and the word read from memory, it builds the next instruction and
// reports how fetch should move on.
//   state        : current realignment state
//   hold         : buffered upper halfword of the previous word
//   mem_data     : word at the current memory address
//   inst         : candidate instruction (16-bit ones zero-extended)
//   is_c         : candidate is a 16-bit instruction
//   consume_word : the memory word is used up and the word pointer moves on
//   pc_inc       : byte increment of pc (2 or 4; 0 when nothing is emitted)
//   next_state   : state after this step
//   emit         : a candidate instruction is available
module fetch_align
    import inst_fetch_ctrl_pkg::*;
(
    input  fetch_state_t state,
    input  logic [15:0]  hold,
    input  logic [31:0]  mem_data,
    output logic [31:0]  inst,
    output logic         is_c,
    output logic         consume_word,
    output logic [2:0]   pc_inc,
    output fetch_state_t next_state,
    output logic         emit
);

    always_comb begin
        inst         = '0;
        is_c         = 1'b0;
        consume_word = 1'b0;
        pc_inc       = 3'd0;
        next_state   = ALIGN;
        emit         = 1'b0;
        unique case (state)
            ALIGN: begin
                emit         = 1'b1;
                consume_word = 1'b1;
                if (is_compressed(mem_data[15:0])) begin
                    // The upper half of this word becomes the next start point.
                    inst       = {16'h0, mem_data[15:0]};
                    is_c       = 1'b1;
                    pc_inc     = 3'd2;
                    next_state = HALF;
                end else begin
                    inst       = mem_data;
                    pc_inc     = 3'd4;
                    next_state = ALIGN;
                end
            end
            HALF: begin
                emit = 1'b1;
                if (is_compressed(hold)) begin
                    // Served entirely from hold; the current word is still unused.
                    inst       = {16'h0, hold};
                    is_c       = 1'b1;
                    pc_inc     = 3'd2;
                    next_state = ALIGN;
                end else begin
                    // Straddling instruction: low half in hold, high half in the new word.
                    inst         = {mem_data[15:0], hold};
                    consume_word = 1'b1;
                    pc_inc       = 3'd4;
                    next_state   = HALF;
                end
            end
            UNALIGNED: begin
                consume_word = 1'b1;
                next_state   = HALF;
            end
            default: begin
                next_state = ALIGN;
            end
        endcase
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: drives the word address of a combinational-read
// instruction memory and realigns the returned words into 16/32-bit RV32IC
// instructions presented through a registered output slot.
//   clk, rst        : clock, synchronous active-high reset
//   fetch_en        : allow fetch to progress
//   redirect_valid  : flush and restart at redirect_pc (bit 0 ignored)
//   mem_addr        : registered word address, mem_data returned the same cycle
//   inst_valid/ready: output slot handshake
//   inst_data/pc/is_c : slot contents
//
// Handshake: the slot transfers on a cycle where inst_valid && inst_ready.
// While inst_valid && !inst_ready, the slot and all fetch state stay frozen.
// A new instruction loads only when fetch_en && (!inst_valid || inst_ready);
// a redirect empties the slot (a same-cycle ready still counts as a transfer).
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W+1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W+1:0] inst_pc,
    output logic              inst_is_c
);

    localparam int                PC_W        = ADDR_W + 2;
    localparam logic [PC_W-1:0]   RESET_PC_H  = RESET_PC & ~PC_W'(1);
    localparam fetch_state_t      RESET_STATE = RESET_PC[1] ? UNALIGNED : ALIGN;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] wptr;
    logic [15:0]       hold;

    logic [31:0]  cand_data;
    logic         cand_is_c;
    logic         consume_word;
    logic [2:0]   pc_inc;
    fetch_state_t align_next;
    logic         emit;

    logic advance;
    logic step;
    logic load;

    fetch_align u_align (
        .state        (state),
        .hold         (hold),
        .mem_data     (mem_data),
        .inst         (cand_data),
        .is_c         (cand_is_c),
        .consume_word (consume_word),
        .pc_inc       (pc_inc),
        .next_state   (align_next),
        .emit         (emit)
    );

    assign advance = fetch_en && (!inst_valid || inst_ready);
    // The UNALIGNED priming step emits nothing, so it never waits on the slot.
    assign step    = (state == UNALIGNED) ? fetch_en : advance;
    assign load    = step && emit;

    assign mem_addr = wptr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_next;
    end

    // Next-state logic; redirect outranks the realignment step
    always_comb begin
        state_next = state;
        if (redirect_valid)
            state_next = redirect_pc[1] ? UNALIGNED : ALIGN;
        else if (step)
            state_next = align_next;
    end

    // Fetch pointers, hold buffer and output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC_H;
            wptr       <= RESET_PC[ADDR_W+1:2];
            hold       <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
            inst_is_c  <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc & ~PC_W'(1);
            wptr       <= redirect_pc[ADDR_W+1:2];
            hold       <= '0;
            inst_valid <= 1'b0;
        end else begin
            if (step) begin
                pc <= pc + PC_W'(pc_inc);
                if (consume_word) begin
                    wptr <= wptr + 1'b1;
                    if (align_next == HALF)
                        hold <= mem_data[31:16];
                end
            end
            if (load) begin
                inst_valid <= 1'b1;
                inst_data  <= cand_data;
                inst_pc    <= pc;
                inst_is_c  <= cand_is_c;
            end else if (inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        inst_is_c;

    logic [31:0] mem [64];

    int total = 0;
    int bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_is_c      (inst_is_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // vector table: inputs driven after the outputs of that row are checked
    typedef struct {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        rv;
        logic [7:0]  rpc;
        logic        e_valid;
        logic [31:0] e_data;
        logic [7:0]  e_pc;
        logic        e_c;
        logic [5:0]  e_ma;
        logic        chk_all;
    } vec_t;

    function automatic vec_t v(input logic r, input logic en, input logic rdy, input logic rv,
                               input logic [7:0] rpc, input logic ev, input logic [31:0] ed,
                               input logic [7:0] ep, input logic ec, input logic [5:0] ema,
                               input logic ca);
        vec_t t;
        t.rst = r; t.en = en; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
        t.e_valid = ev; t.e_data = ed; t.e_pc = ep; t.e_c = ec; t.e_ma = ema; t.chk_all = ca;
        return t;
    endfunction

    // reference model: byte-addressed view of the memory image
    function automatic logic [15:0] hw_at(input logic [7:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    logic [31:0] exp_q[$];
    logic [7:0]  exp_pc_q[$];
    logic        exp_c_q[$];
    logic [7:0]  model_pc;

    task automatic push_next();
        logic [15:0] lo;
        lo = hw_at(model_pc);
        exp_pc_q.push_back(model_pc);
        if (lo[1:0] != 2'b11) begin
            exp_q.push_back({16'h0, lo});
            exp_c_q.push_back(1'b1);
            model_pc = model_pc + 8'd2;
        end else begin
            exp_q.push_back({hw_at(model_pc + 8'd2), lo});
            exp_c_q.push_back(1'b0);
            model_pc = model_pc + 8'd4;
        end
    endtask

    vec_t vecs[24];

    initial begin
        logic [31:0] e_d;
        logic [7:0]  e_p;
        logic        e_c;
        int          accepted;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h45854505;
        mem[1]  = 32'h05134505;
        mem[2]  = 32'h45810140;
        mem[3]  = 32'h45050001;
        mem[4]  = 32'h01400513;
        mem[5]  = 32'h80824501;
        mem[63] = 32'h01400513;

        vecs[0]  = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd0, 1'b1);
        vecs[1]  = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,32'h00004505,8'h00,1'b1,6'd1, 1'b0);
        vecs[2]  = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,32'h00004585,8'h02,1'b1,6'd1, 1'b0);
        vecs[3]  = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,32'h00004505,8'h04,1'b1,6'd2, 1'b0);
        vecs[4]  = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,32'h00004505,8'h04,1'b1,6'd2, 1'b0);
        vecs[5]  = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,32'h00004505,8'h04,1'b1,6'd2, 1'b0);
        vecs[6]  = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,32'h00004505,8'h04,1'b1,6'd2, 1'b0);
        vecs[7]  = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,32'h01400513,8'h06,1'b0,6'd3, 1'b0);
        vecs[8]  = v(1'b0,1'b1,1'b1,1'b1,8'h0E, 1'b1,32'h00004581,8'h0A,1'b1,6'd3, 1'b0);
        vecs[9]  = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd3, 1'b0);
        vecs[10] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd4, 1'b0);
        vecs[11] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,32'h00004505,8'h0E,1'b1,6'd4, 1'b0);
        vecs[12] = v(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,32'h01400513,8'h10,1'b0,6'd5, 1'b0);
        vecs[13] = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd5, 1'b0);
        vecs[14] = v(1'b0,1'b1,1'b1,1'b1,8'h00, 1'b1,32'h00004501,8'h14,1'b1,6'd6, 1'b0);
        vecs[15] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd0, 1'b0);
        vecs[16] = v(1'b0,1'b1,1'b1,1'b1,8'hFC, 1'b1,32'h00004505,8'h00,1'b1,6'd1, 1'b0);
        vecs[17] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd63,1'b0);
        vecs[18] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,32'h01400513,8'hFC,1'b0,6'd0, 1'b0);
        vecs[19] = v(1'b0,1'b1,1'b1,1'b1,8'h06, 1'b1,32'h00004505,8'h00,1'b1,6'd1, 1'b0);
        vecs[20] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd1, 1'b0);
        vecs[21] = v(1'b1,1'b1,1'b1,1'b1,8'h0E, 1'b0,32'h00000000,8'h00,1'b0,6'd2, 1'b0);
        vecs[22] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,32'h00000000,8'h00,1'b0,6'd0, 1'b1);
        vecs[23] = v(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,32'h00004505,8'h00,1'b1,6'd1, 1'b0);

        // directed table: reset state, compressed pairs, straddle, stall,
        // unaligned redirect, fetch_en gating, word-63 wrap, reset mid-straddle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_mem_addr", i), {26'b0, mem_addr}, {26'b0, vecs[i].e_ma});
            if (vecs[i].e_valid || vecs[i].chk_all) begin
                chk($sformatf("v%0d_data", i), inst_data, vecs[i].e_data);
                chk($sformatf("v%0d_pc", i), {24'b0, inst_pc}, {24'b0, vecs[i].e_pc});
                chk($sformatf("v%0d_is_c", i), {31'b0, inst_is_c}, {31'b0, vecs[i].e_c});
            end
            rst            = vecs[i].rst;
            fetch_en       = vecs[i].en;
            inst_ready     = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
        end

        // randomized run against the byte-stream model
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) w[17:16] = 2'b11;
            mem[i] = w;
        end
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete(); exp_pc_q.delete(); exp_c_q.delete();
        model_pc = 8'h00;
        accepted = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst            = 1'b0;
            fetch_en       = ($urandom_range(0, 9) != 0);
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc    = 8'($urandom_range(0, 255));
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) push_next();
                e_d = exp_q.pop_front();
                e_p = exp_pc_q.pop_front();
                e_c = exp_c_q.pop_front();
                chk("rand_data", inst_data, e_d);
                chk("rand_pc", {24'b0, inst_pc}, {24'b0, e_p});
                chk("rand_is_c", {31'b0, inst_is_c}, {31'b0, e_c});
                accepted++;
            end
            if (redirect_valid) begin
                exp_q.delete(); exp_pc_q.delete(); exp_c_q.delete();
                model_pc = redirect_pc & 8'hFE;
            end
        end
        total++;
        if (accepted < 800) begin
            bad++;
            $display("FAIL rand_progress actual=%0d expected>=800", accepted);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
